// File: rtl/mod_pkg.sv
// Shared definitions for the modulo-by-repeated-subtraction unit (datapath and controller).
package mod_pkg;

    localparam int unsigned MOD_WIDTH = 8;

    typedef enum logic {
        SEL_LOAD = 1'b0,
        SEL_SUB  = 1'b1
    } sel_e;

endpackage

// File: rtl/mod_sub_cmp.sv
// Combinational subtract/compare: difference, unsigned less-than and zero-divisor detect.
module mod_sub_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             lt_o,
    output logic             bz_o
);

    assign diff_o = r_i - b_i;
    assign lt_o   = (r_i < b_i);
    assign bz_o   = (b_i == '0);

endmodule

// File: rtl/mod_dp.sv
// Modulo datapath: remainder/divisor/quotient registers with a guarded subtract step.
// Optional registered done flag: define MOD_DP_XREG_EN.
module mod_dp
    import mod_pkg::*;
#(
    parameter int unsigned WIDTH = MOD_WIDTH
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             we,
    input  logic             s,
    output logic             x,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] diff;
    logic             lt;
    logic             bz;
    logic             x_c;

    mod_sub_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .r_i   (r_q),
        .b_i   (b_q),
        .diff_o(diff),
        .lt_o  (lt),
        .bz_o  (bz)
    );

    assign x_c = lt | bz;

    // Step is gated by the unregistered compare so R cannot underflow even
    // when the controller holds we high on the edge where x rises.
    always_comb begin
        r_d = r_q;
        b_d = b_q;
        q_d = q_q;
        if (we) begin
            if (s == SEL_LOAD) begin
                r_d = a_in;
                b_d = b_in;
                q_d = '0;
            end else if (!x_c) begin
                r_d = diff;
                q_d = q_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            b_q <= '0;
            q_q <= '0;
        end else begin
            r_q <= r_d;
            b_q <= b_d;
            q_q <= q_d;
        end
    end

`ifdef MOD_DP_XREG_EN
    logic x_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= 1'b1;
        end else begin
            x_q <= x_c;
        end
    end

    assign x = x_q;
`else
    assign x = x_c;
`endif

    assign remainder = r_q;
    assign quotient  = q_q;
    assign div_zero  = bz;

endmodule
